// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, prefetches words from imem
// into a small queue for decode, and applies execute redirects.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [31:0] LAST_PC = 32'(MEM_WORDS*4-4);

  typedef enum logic {
    FETCH,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t        state;
  state_t        state_nx;
  entry_t        q [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [31:0]   fetch_pc;
  logic [31:0]   seq_pc;
  logic          fault_q;

  logic target_ok;
  logic pop;
  logic push;
  logic flush;
  logic trap;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = q[rptr].instr;
  assign out_pc    = q[rptr].pc;
  assign fault     = fault_q;

  assign target_ok = (redirect_pc[1:0] == 2'b00) &&
                     (redirect_pc <= LAST_PC);

  // Sequential PC wraps from the top of imem back to zero.
  assign seq_pc = (fetch_pc == LAST_PC) ? 32'd0
                                        : fetch_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    trap     = 1'b0;
    unique case (state)
      FETCH: begin
        unique case (1'b1)
          redirect_valid && !target_ok: begin
            flush    = 1'b1;
            trap     = 1'b1;
            state_nx = HALT;
          end
          redirect_valid && target_ok: begin
            flush = 1'b1;
          end
          !redirect_valid: begin
            pop  = out_valid && out_ready;
            push = (count != FULL) || pop;
          end
        endcase
      end
      HALT: begin
        state_nx = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fault_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (trap) begin
        fault_q <= 1'b1;
      end
      // Flushing keeps rptr so the head outputs hold their last value.
      if (flush) begin
        wptr  <= rptr;
        count <= '0;
        if (target_ok) begin
          fetch_pc <= redirect_pc;
        end
      end else begin
        if (push) begin
          q[wptr]  <= '{instr: imem_data, pc: fetch_pc};
          wptr     <= wptr + AW'(1);
          fetch_pc <= seq_pc;
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + (AW+1)'(1);
        end else if (pop && !push) begin
          count <= count - (AW+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl against a queue-based
// reference of the fetch stream.
module tb_imem_fetch_ctrl;

  localparam int          DEPTH = 4;
  localparam int          WORDS = 1024;
  localparam logic [31:0] LAST  = 32'hFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;

  logic [31:0] mem [WORDS];

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] mq [$];
  logic [31:0] mfpc;
  logic        mfault;
  logic        mhalt;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[11:2]];

  imem_fetch_ctrl #(
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH),
    .MEM_WORDS(WORDS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fault         (fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    mfpc   = 32'h0;
    mfault = 1'b0;
    mhalt  = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    bit push;
    if (rst) begin
      model_reset();
    end else if (!mhalt) begin
      if (redirect_valid) begin
        mq.delete();
        if (redirect_pc[1:0] == 2'b00 && redirect_pc <= LAST) begin
          mfpc = redirect_pc;
        end else begin
          mfault = 1'b1;
          mhalt  = 1'b1;
        end
      end else begin
        pop  = (mq.size() != 0) && out_ready;
        push = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(mfpc);
          mfpc = (mfpc == LAST) ? 32'h0 : mfpc + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
    chk("fault", {31'b0, fault}, {31'b0, mfault});
    chk("addr", imem_addr, mfpc);
    if (mq.size() != 0) begin
      chk("pc", out_pc, mq[0]);
      chk("instr", out_instr, mem_word(mq[0]));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'hA000_0000 + i;
    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #1;
    model_reset();
    do_reset();
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);

    // streaming
    out_ready = 1'b1;
    run(10);

    // backpressure
    do_reset();
    out_ready = 1'b0;
    run(10);
    chk("bp_addr", imem_addr, 32'h10);
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    run(8);

    // redirect with three queued entries
    do_reset();
    out_ready = 1'b0;
    run(3);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    chk("rd_valid", {31'b0, out_valid}, 32'h0);
    chk("rd_addr", imem_addr, 32'h200);
    cycle();
    chk("rd_pc", out_pc, 32'h200);
    chk("rd_instr", out_instr, mem[32'h80]);
    run(4);

    // wrap at top of imem
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFC;
    cycle();
    redirect_valid = 1'b0;
    run(6);

    // misaligned target faults, later redirects ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    cycle();
    chk("f1_fault", {31'b0, fault}, 32'h1);
    redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    run(4);
    chk("f1_hold", {31'b0, out_valid}, 32'h0);

    // out-of-range target faults
    do_reset();
    chk("f2_clr", {31'b0, fault}, 32'h0);
    run(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1000;
    cycle();
    redirect_valid = 1'b0;
    chk("f2_fault", {31'b0, fault}, 32'h1);
    run(3);

    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = {20'h0, $urandom_range(0, WORDS-1) * 4};
      if (i % 500 == 250) rst = 1'b1;
      cycle();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the instruction memory.
- Owns the fetch PC and drives the word-aligned byte address to imem, which returns data combinationally in the same cycle.
- Buffers fetched words in a small prefetch queue and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; flags illegal redirect targets.

Parameters:
RESET_PC, 32'h0000_0000, byte address of first fetch after reset; must be word-aligned.
DEPTH, 4, prefetch queue entries (power of two, >=2).
MEM_WORDS, 1024, imem size in 32-bit words; legal byte range 0 .. MEM_WORDS*4-4.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
imem_addr  out  32  byte address to imem; always a multiple of 4.
imem_data  in  32  instruction word at imem_addr, valid in the same cycle.
out_valid  out  1  queue head holds a valid instruction.
out_ready  in  1  decode accepts the head this cycle.
out_instr  out  32  instruction at queue head.
out_pc  out  32  byte address of out_instr.
redirect_valid  in  1  execute requests a new fetch PC.
redirect_pc  in  32  new fetch target, byte address.
fault  out  1  sticky; illegal redirect target seen.

Behaviour:
- Reset: state=FETCH, fetch_pc=RESET_PC, count=0, fault=0, out_valid=0, out_instr=0, out_pc=0. imem_addr=RESET_PC.
- imem_addr is driven from the fetch_pc register; no combinational path from any input.
- States:
  - FETCH: normal operation.
  - HALT: entered only on fault; left only by rst.
- Pop: occurs when out_valid && out_ready (and no redirect in the same cycle).
- Push (FETCH, no redirect):
  - Pushes when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Push writes {imem_data, fetch_pc} to the tail, then fetch_pc <= fetch_pc+4.
  - Wrap: fetch_pc == MEM_WORDS*4-4 advances to 0.
- Full without pop: no push; fetch_pc and imem_addr hold.
- Push+pop same cycle: count unchanged, FIFO order preserved.
- Empty: out_valid=0; out_instr/out_pc hold their last value, and are not checked.
- Latency:
  - The first instruction is valid in the cycle after rst deasserts.
  - Steady state sustains 1 instruction/cycle with out_ready held high.
- Redirect (redirect_valid=1, legal target):
  - Highest priority.
  - Queue is flushed: count=0 and any simultaneous pop is discarded.
  - No push that cycle; fetch_pc <= redirect_pc.
  - Next cycle out_valid=0 and imem_addr=redirect_pc; instruction at redirect_pc is valid the cycle after.
- Illegal redirect:
  - Condition: redirect_pc[1:0]!=0 or redirect_pc>MEM_WORDS*4-4.
  - Response: fault<=1, queue flushed, state<=HALT.
  - In HALT: out_valid=0, no pushes, fetch_pc/imem_addr hold, redirects ignored.
- Redirect in HALT has no effect; fault stays 1 until rst.
- Reset mid-operation: rst in any cycle overrides push/pop/redirect and restores all reset values at the next edge.
- Counter and pointers use clog2(DEPTH)+1 bits for count and clog2(DEPTH) bits for pointers; pointers wrap naturally.

Test Plan:
- Streaming: memory word i = 32'hA000_0000+i, RESET_PC=0, out_ready=1 → out_pc 0x0,0x4,0x8,… with matching data, one per cycle starting 1 cycle after rst falls.
- Backpressure: out_ready=0 for 10 cycles → out_valid=1, count saturates at 4, imem_addr holds 0x10. Then ready=1 → pcs 0x0..0x10 in order, none lost or duplicated.
- Redirect: redirect to 0x200 while queue holds 3 entries and out_ready=1 → next cycle out_valid=0. Following cycle out_pc=0x200, out_instr=mem[0x80].
- Wrap: redirect to 0xFFC → outputs pc 0xFFC then 0x000.
- Faults:
  - Redirect to 0x202 → fault=1 next cycle, out_valid=0 thereafter.
  - A later redirect to 0x100 is ignored.
  - rst clears fault and restarts at RESET_PC.
  - Repeat with redirect_pc=0x1000 → fault=1.
- Random: 2000 cycles of random out_ready and sparse random legal redirects, checked against a reference model → every popped {pc,instr} equals {expected pc, mem[pc>>2]}.
